// File: rtl/wb_mem_nport.sv
// wb_mem_nport: multi-port pipelined Wishbone slave memory.
//
// NUM_PORTS independent slave ports share one word-addressed array on a
// single clock. Every port can issue one request per cycle. Each request
// gets exactly one ack (in range) or err (out of range), READ_LATENCY
// cycles after acceptance.
//
// Only two in-range writes to the same word in one cycle can conflict.
// The lowest-index writer wins. Every higher-index writer to that word is
// stalled for that cycle and must retry.
//
// Optional build macro:
//   WB_MEM_FWD_EN - a read that hits a word written in the same cycle
//                   returns the merged new data. Without the macro it
//                   returns the old (pre-write) contents.
//
// Memory contents are not reset. Writes are suppressed while wb_rst_ni is low.
module wb_mem_nport #(
    parameter int NUM_PORTS    = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_ni,
    input  logic [NUM_PORTS-1:0]              wb_cyc_i,
    input  logic [NUM_PORTS-1:0]              wb_stb_i,
    input  logic [NUM_PORTS-1:0]              wb_we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic [NUM_PORTS*32-1:0]           wb_adr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wb_dat_i,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   wb_dat_o,
    output logic [NUM_PORTS-1:0]              wb_ack_o,
    output logic [NUM_PORTS-1:0]              wb_err_o,
    output logic [NUM_PORTS-1:0]              wb_stall_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Per-port unpacked views of the flat buses
    logic [31:0]           adr_s  [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] word_s [NUM_PORTS];
    logic [NB-1:0]         sel_s  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdat_s [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rdat_s [NUM_PORTS];
    logic [NUM_PORTS-1:0]  oor_s;
    logic [2*NUM_PORTS-1:0] unused_adr_s;

    // Request classification
    logic [NUM_PORTS-1:0]  req_s;
    logic [NUM_PORTS-1:0]  wr_req_s;
    logic [NUM_PORTS-1:0]  stall_s;
    logic [NUM_PORTS-1:0]  acc_s;
    logic [NUM_PORTS-1:0]  wr_acc_s;

    // Response entering the output register stage
    logic [NUM_PORTS-1:0]  out_vld_s;
    logic [NUM_PORTS-1:0]  out_err_s;
    logic [NUM_PORTS-1:0]  out_rd_s;
    logic [DATA_WIDTH-1:0] out_dat_s [NUM_PORTS];

    // Registered outputs
    logic [NUM_PORTS-1:0]  ack_q;
    logic [NUM_PORTS-1:0]  err_q;
    logic [DATA_WIDTH-1:0] dat_q [NUM_PORTS];

    // Split the flat port buses into per-port fields and decode the address
    always_comb begin
        oor_s        = '0;
        unused_adr_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            adr_s[p]  = wb_adr_i[p*32 +: 32];
            word_s[p] = adr_s[p][ADDR_WIDTH+1:2];
            oor_s[p]  = |adr_s[p][31:ADDR_WIDTH+2];
            sel_s[p]  = wb_sel_i[p*NB +: NB];
            wdat_s[p] = wb_dat_i[p*DATA_WIDTH +: DATA_WIDTH];
            // Byte offset within the word plays no part in addressing
            unused_adr_s[p*2 +: 2] = adr_s[p][1:0];
        end
    end

    assign req_s    = wb_cyc_i & wb_stb_i;
    assign wr_req_s = req_s & wb_we_i & ~oor_s;

    // Stall a writer when a lower-index port writes the same in-range word
    always_comb begin
        stall_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < p; q++) begin
                stall_s[p] = stall_s[p]
                           | (wr_req_s[q] & wr_req_s[p] & (word_s[q] == word_s[p]));
            end
        end
    end

    assign acc_s      = req_s & ~stall_s;
    assign wr_acc_s   = acc_s & wb_we_i & ~oor_s;
    assign wb_stall_o = stall_s;

    // Read data at acceptance, optionally merged with this cycle's writes
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdat_s[p] = mem_q[word_s[p]];
`ifdef WB_MEM_FWD_EN
            // Collisions are already resolved, so at most one accepted
            // writer can hit each word; the merge order does not matter.
            for (int q = 0; q < NUM_PORTS; q++) begin
                for (int b = 0; b < NB; b++) begin
                    rdat_s[p][b*8 +: 8] =
                        (wr_acc_s[q] && (word_s[q] == word_s[p]) && sel_s[q][b])
                        ? wdat_s[q][b*8 +: 8] : rdat_s[p][b*8 +: 8];
                end
            end
`endif
        end
    end

    // Byte-lane writes from accepted in-range writers; none while in reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_ni) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_acc_s[p] && sel_s[p][b]) begin
                        mem_q[word_s[p]][b*8 +: 8] <= wdat_s[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [NUM_PORTS-1:0]  s1_vld_q;
            logic [NUM_PORTS-1:0]  s1_err_q;
            logic [NUM_PORTS-1:0]  s1_rd_q;
            logic [DATA_WIDTH-1:0] s1_dat_q [NUM_PORTS];

            // Extra pipeline stage holding the response captured at acceptance
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    s1_vld_q <= '0;
                    s1_err_q <= '0;
                    s1_rd_q  <= '0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        s1_dat_q[p] <= '0;
                    end
                end else begin
                    s1_vld_q <= acc_s;
                    s1_err_q <= oor_s;
                    s1_rd_q  <= ~wb_we_i;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (acc_s[p]) begin
                            s1_dat_q[p] <= rdat_s[p];
                        end
                    end
                end
            end

            // Discard a staged response once its master abandons the cycle
            always_comb begin
                out_vld_s = s1_vld_q & wb_cyc_i;
                out_err_s = s1_err_q;
                out_rd_s  = s1_rd_q;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    out_dat_s[p] = s1_dat_q[p];
                end
            end
        end else begin : g_lat1
            // Single-cycle latency: the accepted request feeds the output stage directly
            always_comb begin
                out_vld_s = acc_s;
                out_err_s = oor_s;
                out_rd_s  = ~wb_we_i;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    out_dat_s[p] = rdat_s[p];
                end
            end
        end
    endgenerate

    // Output stage: one-cycle ack/err pulses; dat_o moves only on a read ack
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= '0;
            err_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                dat_q[p] <= '0;
            end
        end else begin
            ack_q <= out_vld_s & ~out_err_s;
            err_q <= out_vld_s & out_err_s;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (out_vld_s[p] && !out_err_s[p] && out_rd_s[p]) begin
                    dat_q[p] <= out_dat_s[p];
                end
            end
        end
    end

    // Pack per-port read data back into the flat output bus
    always_comb begin
        wb_dat_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            wb_dat_o[p*DATA_WIDTH +: DATA_WIDTH] = dat_q[p];
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_mem_nport.sv
// Directed testbench for wb_mem_nport.
// u_dut : 3 ports, READ_LATENCY=1 (main function, collisions, out-of-range, forwarding)
// u_dut2: 1 port,  READ_LATENCY=2 (latency, cycle abandonment, reset mid-flight)
module tb_wb_mem_nport;

`ifdef WB_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    logic [2:0]  cyc, stb, we;
    logic [11:0] sel;
    logic [95:0] adr, dat;
    logic [95:0] dat_o;
    logic [2:0]  ack, err, stall;

    logic        c2, s2, w2;
    logic [3:0]  sel2;
    logic [31:0] a2, d2;
    logic [31:0] q2;
    logic        ack2, err2, st2;

    int n_tests;
    int n_fail;

    wb_mem_nport #(.NUM_PORTS(3), .DATA_WIDTH(32), .ADDR_WIDTH(9), .READ_LATENCY(1)) u_dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
        .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_stall_o(stall)
    );

    wb_mem_nport #(.NUM_PORTS(1), .DATA_WIDTH(32), .ADDR_WIDTH(9), .READ_LATENCY(2)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wb_cyc_i(c2), .wb_stb_i(s2), .wb_we_i(w2), .wb_sel_i(sel2),
        .wb_adr_i(a2), .wb_dat_i(d2),
        .wb_dat_o(q2), .wb_ack_o(ack2), .wb_err_o(err2), .wb_stall_o(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        cyc[p] = 1'b1;
        stb[p] = 1'b1;
        we[p]  = w;
        adr[p*32 +: 32] = a;
        dat[p*32 +: 32] = d;
        sel[p*4 +: 4]   = s;
    endtask

    task automatic idle_all();
        cyc = 3'b000;
        stb = 3'b000;
        we  = 3'b000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        cyc = 3'b000; stb = 3'b000; we = 3'b000;
        sel = 12'h000; adr = 96'h0; dat = 96'h0;
        c2 = 1'b0; s2 = 1'b0; w2 = 1'b0; sel2 = 4'h0; a2 = 32'h0; d2 = 32'h0;

        // Reset state
        #2;
        chk("rst_ack", {61'h0, ack}, 64'h0);
        chk("rst_err", {61'h0, err}, 64'h0);
        chk("rst_dat", dat_o[63:0], 64'h0);
        chk("rst_ack2", {63'h0, ack2}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Port0 writes DEADBEEF to 0x010 and port2 clears word 0 in the same cycle (no collision)
        req(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF);
        req(2, 1'b1, 32'h000, 32'h0, 4'hF);
        #1 chk("t1_nostall", {61'h0, stall}, 64'h0);
        step();
        chk("t1_wr_ack", {61'h0, ack}, 64'h5);
        chk("t1_wr_err", {61'h0, err}, 64'h0);
        @(negedge clk); idle_all(); req(1, 1'b0, 32'h010, 32'h0, 4'h0);
        step();
        chk("t1_rd_ack", {61'h0, ack}, 64'h2);
        chk("t1_rd_dat", {32'h0, dat_o[63:32]}, 64'hDEADBEEF);
        @(negedge clk); idle_all();
        step();
        chk("t1_ack_pulse", {61'h0, ack}, 64'h0);
        chk("t1_dat_hold", {32'h0, dat_o[63:32]}, 64'hDEADBEEF);

        // Byte-lane write: 0x11223344 then AABBCCDD with sel=0x5
        @(negedge clk); idle_all(); req(0, 1'b1, 32'h020, 32'h11223344, 4'hF);
        step();
        chk("t2_w0_ack", {61'h0, ack}, 64'h1);
        @(negedge clk); idle_all(); req(2, 1'b1, 32'h020, 32'hAABBCCDD, 4'h5);
        step();
        chk("t2_w2_ack", {61'h0, ack}, 64'h4);
        @(negedge clk); idle_all(); req(0, 1'b0, 32'h020, 32'h0, 4'h0);
        step();
        chk("t2_rd_ack", {61'h0, ack}, 64'h1);
        chk("t2_rd_dat", {32'h0, dat_o[31:0]}, 64'h11BB33DD);

        // Same-word write collision between port0 and port2
        @(negedge clk); idle_all();
        req(0, 1'b1, 32'h040, 32'h1, 4'hF);
        req(2, 1'b1, 32'h040, 32'h2, 4'hF);
        #1 chk("t3_stall", {61'h0, stall}, 64'h4);
        step();
        chk("t3_ack", {61'h0, ack}, 64'h1);
        @(negedge clk); idle_all();
        req(2, 1'b1, 32'h040, 32'h2, 4'hF);
        req(1, 1'b0, 32'h040, 32'h0, 4'h0);
        #1 chk("t3_retry_nostall", {61'h0, stall}, 64'h0);
        step();
        chk("t3_retry_ack", {61'h0, ack}, 64'h6);
        chk("t3_mem_first", {32'h0, dat_o[63:32]}, FWD ? 64'h2 : 64'h1);
        @(negedge clk); idle_all(); req(1, 1'b0, 32'h040, 32'h0, 4'h0);
        step();
        chk("t3_mem_final", {32'h0, dat_o[63:32]}, 64'h2);

        // Out-of-range read on port1 and write on port0 (address 0x1000)
        @(negedge clk); idle_all();
        req(1, 1'b0, 32'h1000, 32'h0, 4'h0);
        req(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        #1 chk("t4_nostall", {61'h0, stall}, 64'h0);
        step();
        chk("t4_err", {61'h0, err}, 64'h3);
        chk("t4_noack", {61'h0, ack}, 64'h0);
        chk("t4_dat_hold", {32'h0, dat_o[63:32]}, 64'h2);
        @(negedge clk); idle_all(); req(1, 1'b0, 32'h000, 32'h0, 4'h0);
        step();
        chk("t4_err_pulse", {61'h0, err}, 64'h0);
        chk("t4_mem_kept", {32'h0, dat_o[63:32]}, 64'h0);

        // Same-cycle write and read of word 0
        @(negedge clk); idle_all();
        req(0, 1'b1, 32'h000, 32'h55, 4'hF);
        req(1, 1'b0, 32'h000, 32'h0, 4'h0);
        step();
        chk("t5_ack", {61'h0, ack}, 64'h3);
        chk("t5_rw_dat", {32'h0, dat_o[63:32]}, FWD ? 64'h55 : 64'h0);
        @(negedge clk); idle_all(); req(1, 1'b0, 32'h000, 32'h0, 4'h0);
        step();
        chk("t5_after", {32'h0, dat_o[63:32]}, 64'h55);

        // Back-to-back reads on port0; byte offset bits ignored
        @(negedge clk); idle_all(); req(0, 1'b0, 32'h013, 32'h0, 4'h0);
        step();
        chk("t6_b2b_dat0", {32'h0, dat_o[31:0]}, 64'hDEADBEEF);
        @(negedge clk); req(0, 1'b0, 32'h020, 32'h0, 4'h0);
        step();
        chk("t6_b2b_ack1", {61'h0, ack}, 64'h1);
        chk("t6_b2b_dat1", {32'h0, dat_o[31:0]}, 64'h11BB33DD);
        @(negedge clk); idle_all();
        step();
        chk("t6_ack_end", {61'h0, ack}, 64'h0);

        // READ_LATENCY=2 instance: write then read
        @(negedge clk); c2 = 1'b1; s2 = 1'b1; w2 = 1'b1; a2 = 32'h004; d2 = 32'hCAFEF00D; sel2 = 4'hF;
        step();
        chk("l2_w_lat1", {63'h0, ack2}, 64'h0);
        @(negedge clk); s2 = 1'b0;
        step();
        chk("l2_w_ack", {63'h0, ack2}, 64'h1);
        @(negedge clk); s2 = 1'b1; w2 = 1'b0;
        step();
        chk("l2_r_lat1", {63'h0, ack2}, 64'h0);
        @(negedge clk); s2 = 1'b0;
        step();
        chk("l2_r_ack", {63'h0, ack2}, 64'h1);
        chk("l2_r_dat", {32'h0, q2}, 64'hCAFEF00D);
        @(negedge clk); c2 = 1'b0;
        step();
        chk("l2_ack_pulse", {63'h0, ack2}, 64'h0);

        // Cycle dropped before delivery: response discarded
        @(negedge clk); c2 = 1'b1; s2 = 1'b1; w2 = 1'b0; a2 = 32'h004;
        step();
        @(negedge clk); c2 = 1'b0; s2 = 1'b0;
        step();
        chk("l2_drop_a", {63'h0, ack2}, 64'h0);
        step();
        chk("l2_drop_b", {63'h0, ack2}, 64'h0);

        // Reset asserted while a read is in flight
        @(negedge clk); c2 = 1'b1; s2 = 1'b1; w2 = 1'b0; a2 = 32'h004;
        step();
        @(negedge clk); s2 = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst_fly_ack2", {63'h0, ack2}, 64'h0);
        chk("rst_fly_dat2", {32'h0, q2}, 64'h0);
        chk("rst_fly_dat", dat_o[63:0], 64'h0);
        step();
        chk("rst_hold_ack2", {63'h0, ack2}, 64'h0);
        chk("rst_hold_err2", {63'h0, err2}, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_ghost_ack", {63'h0, ack2}, 64'h0);
        end
        @(negedge clk); s2 = 1'b1;
        step();
        @(negedge clk); s2 = 1'b0;
        step();
        chk("rst_mem_ack", {63'h0, ack2}, 64'h1);
        chk("rst_mem_kept", {32'h0, q2}, 64'hCAFEF00D);
        @(negedge clk); c2 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_mem_nport.md
WB_MEM_NPORT -- requirements
Module: wb_mem_nport

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3: number of independent pipelined Wishbone slave ports, range 1..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width, a multiple of 8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9: word-address bits; depth = 2**ADDR_WIDTH words.
REQ-004 SHALL have parameter READ_LATENCY, default 1: cycles from accepted request to ack/err, legal values 1 or 2.
REQ-005 SHALL have ports wb_clk_i input 1 (single clock, all ports) and wb_rst_ni input 1 (asynchronous, active-low reset).
REQ-006 SHALL have ports wb_cyc_i input NUM_PORTS and wb_stb_i input NUM_PORTS: per-port cycle and strobe.
REQ-007 SHALL have ports wb_we_i input NUM_PORTS and wb_sel_i input NUM_PORTS*DATA_WIDTH/8: per-port write enable and byte lanes.
REQ-008 SHALL have ports wb_adr_i input NUM_PORTS*32 (byte address) and wb_dat_i input NUM_PORTS*DATA_WIDTH: write data.
REQ-009 SHALL have ports wb_dat_o output NUM_PORTS*DATA_WIDTH, wb_ack_o output NUM_PORTS, wb_err_o output NUM_PORTS and wb_stall_o output NUM_PORTS.
REQ-010 SHALL pack port p in slice p of every vector, port 0 in the LSBs.

Function
REQ-011 SHALL accept a request on port p in a cycle where cyc[p]&stb[p]&!stall[p].
REQ-012 SHALL use word index adr[ADDR_WIDTH+1:2]; adr[1:0] ignored.
REQ-013 SHALL treat a request with any of adr[31:ADDR_WIDTH+2] nonzero as out of range: no memory access, err instead of ack.
REQ-014 SHALL write each byte lane with sel set on the accepting edge; sel=0 write still acks.
REQ-015 SHALL return mem[word] on dat_o of a read, valid in the same cycle as ack.
REQ-016 SHALL assert ack (or err) for exactly one cycle, exactly READ_LATENCY cycles after acceptance; a port may issue one request per cycle back-to-back.
REQ-017 SHALL hold dat_o of a port unchanged except when a read ack is presented.
REQ-018 SHALL resolve two or more in-range writes to the same word in one cycle by fixed priority: lowest port index accepted, every higher-index colliding writer gets stall=1 that cycle and is not accepted.
REQ-019 SHALL never stall reads, non-colliding writes, or out-of-range requests; stall is combinational from current inputs.
REQ-020 SHALL discard (no ack/err) the pending response of a port whose cyc drops before delivery; any write already performed persists.
REQ-021 SHALL, on a read and a write to the same word in the same cycle, behave per REQ-027/REQ-028.

Reset
REQ-022 SHALL, while wb_rst_ni=0, force ack=0, err=0 and dat_o=0 on all ports, asynchronously.
REQ-023 SHALL cancel all in-flight responses on reset assertion; none appear after release.
REQ-024 SHALL leave memory contents unchanged by reset and block writes while reset is asserted.
REQ-025 SHALL accept requests from the first rising edge with wb_rst_ni=1.

Configuration
REQ-026 SHALL use macro WB_MEM_FWD_EN to select same-cycle write-to-read forwarding.
REQ-027 SHALL, with WB_MEM_FWD_EN defined, return to a read the word merged with the bytes written that cycle by the accepted writer (new data).
REQ-028 SHALL, with WB_MEM_FWD_EN undefined, return the pre-write contents (old data) in that case.

Verification
REQ-029 SHALL check: port0 write 0xDEADBEEF to 0x010 sel=0xF, then port1 read 0x010 -> ack exactly READ_LATENCY cycles after acceptance, dat_o=0xDEADBEEF.
REQ-030 SHALL check: word 0x020=0x11223344, port2 write 0xAABBCCDD sel=0x5 -> read returns 0x11BB33DD.
REQ-031 SHALL check: ports 0 and 2 write 0x1 and 0x2 to 0x040 same cycle -> stall[2]=1, mem=0x1; port2 retries next cycle -> mem=0x2.
REQ-032 SHALL check: port1 read adr=0x0000_1000 (ADDR_WIDTH=9) -> err[1] pulses once, ack[1]=0, memory unchanged.
REQ-033 SHALL check: port0 writes 0x55 while port1 reads the same word, old value 0x00 -> dat_o=0x55 with WB_MEM_FWD_EN, 0x00 without.
REQ-034 SHALL check: reset asserted one cycle after a read is accepted with READ_LATENCY=2 -> no ack after release, all outputs 0 during reset.
